// File: rtl/ifarr_pkg.sv
// Shared types and constants for the interface-array collector.
package ifarr_pkg;

  localparam int unsigned MAX_CH = 16;

  typedef enum logic [0:0] {
    ARB_RR,
    ARB_FIXED
  } arb_mode_e;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } state_e;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned ch_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_if.sv
// Valid/ready channel carrying one payload word per beat.
interface chan_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] value;

  modport src (output valid, output value, input ready);
  modport snk (input valid, input value, output ready);

endinterface

// File: rtl/ifarr_arb.sv
// Single-grant arbiter: round-robin from ptr, or fixed lowest-index priority.
module ifarr_arb
  import ifarr_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  arb_mode_e       mode,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx
);

  // Scan requesters starting at the search base, first hit wins.
  always_comb begin
    int unsigned base;
    int unsigned c;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    base      = (mode == ARB_RR) ? 32'(ptr) : 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      c = (base + k) % N_CH;
      if (!found && req[c]) begin
        grant[c]  = 1'b1;
        grant_idx = CH_W'(c);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifarr_collector.sv
// Collects beats from an array of valid/ready channels into one output register,
// keeping a running payload sum and a beat count.
module ifarr_collector
  import ifarr_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = 16,
  parameter arb_mode_e   MODE   = ARB_RR,
  localparam int unsigned CH_W  = ch_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  chan_if.snk               in_ifs [N_CH-1:0],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [SUM_W-1:0]  sum_out,
  output logic [15:0]       beat_cnt
);

  if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_n_ch
    $error("ifarr_collector: N_CH out of range");
  end

  state_e            state_q;
  logic [CH_W-1:0]   ptr_q;
  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   req_gated;
  logic [N_CH-1:0]   grant;
  logic [CH_W-1:0]   grant_idx;
  logic [DATA_W-1:0] ch_value [N_CH];
  logic [DATA_W-1:0] sel_value;
  logic              can_accept;
  logic              fire;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    assign req[g]          = in_ifs[g].valid;
    assign ch_value[g]     = in_ifs[g].value;
    assign in_ifs[g].ready = grant[g];
  end

  // Requests are masked rather than the grant, so ready never rises while stalled or in reset.
  assign can_accept = !rst && ((state_q == StEmpty) || out_ready);
  assign req_gated  = can_accept ? req : '0;
  assign fire       = |grant;
  assign out_valid  = (state_q == StFull);

  ifarr_arb #(
    .N_CH(N_CH)
  ) u_arb (
    .req      (req_gated),
    .ptr      (ptr_q),
    .mode     (MODE),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // AND-OR mux of the granted channel's payload.
  always_comb begin
    sel_value = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sel_value = sel_value | (ch_value[i] & {DATA_W{grant[i]}});
    end
  end

  // Output register FSM with running sum, beat count and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEmpty;
      out_data <= '0;
      out_ch   <= '0;
      sum_out  <= '0;
      beat_cnt <= '0;
      ptr_q    <= '0;
    end else if (fire) begin
      state_q  <= StFull;
      out_data <= sel_value;
      out_ch   <= grant_idx;
      sum_out  <= sum_out + SUM_W'(sel_value);
      beat_cnt <= beat_cnt + 16'd1;
      if (MODE == ARB_RR) begin
        ptr_q <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      end
    end else if (state_q == StFull && out_ready) begin
      state_q <= StEmpty;
    end
  end

endmodule

// File: tb/tb_ifarr_collector.sv
// Three collectors (round-robin, fixed priority, 8-bit sum) share one stimulus stream;
// a behavioural model predicts grants and beats, a negedge monitor scores the outputs.
module tb_ifarr_collector;
  import ifarr_pkg::*;

  localparam int N  = 4;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] vld;
  logic [7:0]   val [N];
  logic         oready;

  chan_if #(.DATA_W(8)) ifs0 [N-1:0] ();
  chan_if #(.DATA_W(8)) ifs1 [N-1:0] ();
  chan_if #(.DATA_W(8)) ifs2 [N-1:0] ();

  wire [ND-1:0]         ov;
  wire [ND-1:0][7:0]    od;
  wire [ND-1:0][1:0]    och;
  wire [ND-1:0][15:0]   sm;
  wire [ND-1:0][15:0]   cnt;
  wire [ND-1:0][N-1:0]  rdy;
  wire [7:0]            sm8;

  assign sm[2] = {8'h00, sm8};

  for (genvar i = 0; i < N; i++) begin : g_src
    assign ifs0[i].valid = vld[i];
    assign ifs0[i].value = val[i];
    assign rdy[0][i]     = ifs0[i].ready;
    assign ifs1[i].valid = vld[i];
    assign ifs1[i].value = val[i];
    assign rdy[1][i]     = ifs1[i].ready;
    assign ifs2[i].valid = vld[i];
    assign ifs2[i].value = val[i];
    assign rdy[2][i]     = ifs2[i].ready;
  end

  ifarr_collector #(.N_CH(N), .DATA_W(8), .SUM_W(16), .MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .in_ifs(ifs0), .out_valid(ov[0]), .out_ready(oready),
    .out_data(od[0]), .out_ch(och[0]), .sum_out(sm[0]), .beat_cnt(cnt[0])
  );

  ifarr_collector #(.N_CH(N), .DATA_W(8), .SUM_W(16), .MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .in_ifs(ifs1), .out_valid(ov[1]), .out_ready(oready),
    .out_data(od[1]), .out_ch(och[1]), .sum_out(sm[1]), .beat_cnt(cnt[1])
  );

  ifarr_collector #(.N_CH(N), .DATA_W(8), .SUM_W(8), .MODE(ARB_RR)) dut_w8 (
    .clk(clk), .rst(rst), .in_ifs(ifs2), .out_valid(ov[2]), .out_ready(oready),
    .out_data(od[2]), .out_ch(och[2]), .sum_out(sm8), .beat_cnt(cnt[2])
  );

  typedef struct {
    int data;
    int ch;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t q2[$];

  arb_mode_e    d_mode  [ND] = '{ARB_RR, ARB_FIXED, ARB_RR};
  int           sum_mod [ND] = '{65536, 65536, 256};
  bit           m_held  [ND];
  int           m_ptr   [ND];
  int           m_sum   [ND];
  int           m_cnt   [ND];
  int           m_g     [ND];
  logic [N-1:0] exp_rdy [ND];
  int           exp_sum [ND];
  int           exp_cnt [ND];
  bit           mon_en = 1'b0;
  int           n_checks = 0;
  int           n_errs = 0;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic beat_t qfront(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int d);
    case (d)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int d, input beat_t b);
    case (d)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic qclear(input int d);
    case (d)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Which requester wins: first at/after ptr (round-robin) or lowest index (fixed).
  function automatic int pick(input arb_mode_e mode, input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mode == ARB_RR) ? (ptr + k) % N : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Predict this cycle's grant, advance one clock, then commit the model.
  task automatic step();
    int gv [ND];
    bit can;
    for (int d = 0; d < ND; d++) begin
      can      = !rst && (!m_held[d] || oready);
      m_g[d]   = can ? pick(d_mode[d], m_ptr[d], vld) : -1;
      exp_rdy[d] = (m_g[d] >= 0) ? (N'(1) << m_g[d]) : '0;
      gv[d]    = (m_g[d] >= 0) ? int'(val[m_g[d]]) : 0;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_held[d] = 1'b0;
        m_ptr[d]  = 0;
        m_sum[d]  = 0;
        m_cnt[d]  = 0;
        qclear(d);
      end else if (m_g[d] >= 0) begin
        beat_t b;
        m_sum[d]  = (m_sum[d] + gv[d]) % sum_mod[d];
        m_cnt[d]  = (m_cnt[d] + 1) % 65536;
        m_ptr[d]  = (m_g[d] + 1) % N;
        m_held[d] = 1'b1;
        b.data    = gv[d];
        b.ch      = m_g[d];
        qpush(d, b);
      end else if (m_held[d] && oready) begin
        m_held[d] = 1'b0;
      end
      exp_sum[d] = m_sum[d];
      exp_cnt[d] = m_cnt[d];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    step();
    rst = 1'b0;
  endtask

  // Monitor: compare presented beats against the scoreboard, drain on out_ready.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < ND; d++) begin
        chk("ready", d, int'(rdy[d]), int'(exp_rdy[d]));
        chk("sum_out", d, int'(sm[d]), exp_sum[d]);
        chk("beat_cnt", d, int'(cnt[d]), exp_cnt[d]);
        chk("out_valid", d, int'(ov[d]), (qsize(d) > 0) ? 1 : 0);
        if (qsize(d) > 0 && ov[d]) begin
          beat_t b;
          b = qfront(d);
          chk("out_data", d, int'(od[d]), b.data);
          chk("out_ch", d, int'(och[d]), b.ch);
          if (oready) qpop(d);
        end
      end
    end
  end

  initial begin
    int seq_a [5] = '{0, 1, 2, 3, 0};
    int seen  [N];

    rst    = 1'b1;
    vld    = '0;
    oready = 1'b0;
    for (int i = 0; i < N; i++) val[i] = 8'h00;
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;

    // Round-robin with every channel requesting.
    do_reset();
    oready = 1'b1;
    vld    = '1;
    val    = '{8'd10, 8'd20, 8'd30, 8'd40};
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_seq", 0, int'(och[0]), seq_a[k]);
      if (k == 3) begin
        chk("rr_sum_100", 0, int'(sm[0]), 100);
        chk("rr_cnt_4", 0, int'(cnt[0]), 4);
      end
    end

    // Fixed priority: ch1 always beats ch3.
    do_reset();
    oready = 1'b1;
    vld    = 4'b1010;
    val    = '{8'd11, 8'd22, 8'd33, 8'd44};
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fixed_ch", 1, int'(och[1]), 1);
      chk("fixed_no_rdy3", 1, int'(rdy[1][3]), 0);
    end

    // Backpressure hold.
    do_reset();
    oready = 1'b1;
    vld    = 4'b0100;
    val[2] = 8'h5A;
    step();
    oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_data", 0, int'(od[0]), 8'h5A);
      chk("stall_ch", 0, int'(och[0]), 2);
      chk("stall_rdy", 0, int'(rdy[0]), 0);
    end
    oready = 1'b1;
    vld    = '0;
    step();
    chk("stall_drain_valid", 0, int'(ov[0]), 0);
    chk("stall_drain_cnt", 0, int'(cnt[0]), 1);

    // 8-bit running sum wraps.
    do_reset();
    oready = 1'b1;
    vld    = 4'b0001;
    val[0] = 8'd200;
    step();
    val[0] = 8'd100;
    step();
    vld = '0;
    chk("sum_wrap", 2, int'(sm8), 44);

    // Reset while holding a beat with ptr=2.
    do_reset();
    oready = 1'b1;
    vld    = 4'b0010;
    val[1] = 8'd77;
    step();
    chk("pre_rst_valid", 0, int'(ov[0]), 1);
    rst = 1'b1;
    vld = '1;
    step();
    rst = 1'b0;
    chk("rst_valid", 0, int'(ov[0]), 0);
    chk("rst_sum", 0, int'(sm[0]), 0);
    chk("rst_cnt", 0, int'(cnt[0]), 0);
    #1;
    chk("post_rst_rdy", 0, int'(rdy[0]), 1);
    step();
    chk("post_rst_ch", 0, int'(och[0]), 0);

    // Loopback: values i+100 from every source.
    do_reset();
    oready = 1'b1;
    for (int i = 0; i < N; i++) begin
      vld[i]  = 1'b1;
      val[i]  = 8'(i + 100);
      seen[i] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (od[0] >= 8'd100 && od[0] < 8'd104) seen[int'(od[0]) - 100]++;
    end
    for (int i = 0; i < N; i++) chk("loop_once", 0, seen[i], 1);
    chk("loop_sum", 0, int'(sm[0]), 406);

    // Randomised traffic with occasional resets.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      vld = N'($urandom);
      for (int i = 0; i < N; i++) val[i] = 8'($urandom);
      oready = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 49) == 0);
      step();
    end
    rst    = 1'b0;
    vld    = '0;
    oready = 1'b1;
    step();
    step();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
